// File: rtl/pong_pkg.sv
// Shared Pong definitions: state and bounce encodings, screen geometry defaults
// and the ball payload used by the controller and the collision checker.
package pong_pkg;

    localparam int unsigned SCREEN_X_DEF    = 640;
    localparam int unsigned SCREEN_Y_DEF    = 480;
    localparam int unsigned PADDLE_L_X_DEF  = 16;
    localparam int unsigned PADDLE_R_X_DEF  = 616;
    localparam int unsigned PADDLE_W_DEF    = 8;
    localparam int unsigned PADDLE_H_DEF    = 64;
    localparam int unsigned WIN_SCORE_DEF   = 9;
    localparam int unsigned SERVE_DELAY_DEF = 1000;

    localparam int unsigned POS_W    = 10;
    localparam int unsigned SIZE_W   = 8;
    localparam int unsigned SUM_W    = 11;
    localparam int unsigned SCORE_W  = 4;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned BOUNCE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_SCORED    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    typedef enum logic [BOUNCE_W-1:0] {
        BOUNCE_NONE    = 2'b00,
        BOUNCE_PADDLE  = 2'b01,
        BOUNCE_WALL    = 2'b10,
        BOUNCE_RETHROW = 2'b11
    } bounce_t;

    typedef struct packed {
        logic [POS_W-1:0]  x;
        logic [POS_W-1:0]  y;
        logic [SIZE_W-1:0] size_x;
        logic [SIZE_W-1:0] size_y;
    } ball_t;

    // Saturating point award: a score never climbs past the winning total.
    function automatic logic [SCORE_W-1:0] score_inc(
        input logic [SCORE_W-1:0] score,
        input logic [SCORE_W-1:0] limit
    );
        return (score >= limit) ? score : score + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/pong_collide.sv
// Combinational ball/paddle/wall contact detector; all sums are 11 bits so
// edge positions near the screen limits never wrap.
module pong_collide
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_X   = SCREEN_X_DEF,
    parameter int unsigned SCREEN_Y   = SCREEN_Y_DEF,
    parameter int unsigned PADDLE_L_X = PADDLE_L_X_DEF,
    parameter int unsigned PADDLE_R_X = PADDLE_R_X_DEF,
    parameter int unsigned PADDLE_W   = PADDLE_W_DEF,
    parameter int unsigned PADDLE_H   = PADDLE_H_DEF
) (
    input  ball_t             i_ball,
    input  logic [POS_W-1:0]  i_paddle_l_y,
    input  logic [POS_W-1:0]  i_paddle_r_y,
    output logic              o_miss_l,
    output logic              o_miss_r,
    output logic              o_pad,
    output logic              o_wall
);

    logic [SUM_W-1:0] w_x_lo;
    logic [SUM_W-1:0] w_x_hi;
    logic [SUM_W-1:0] w_y_lo;
    logic [SUM_W-1:0] w_y_hi;
    logic [SUM_W-1:0] w_pl_lo;
    logic [SUM_W-1:0] w_pl_hi;
    logic [SUM_W-1:0] w_pr_lo;
    logic [SUM_W-1:0] w_pr_hi;
    logic             w_ovl_l;
    logic             w_ovl_r;
    logic             w_pad_l;
    logic             w_pad_r;

    assign w_x_lo  = SUM_W'(i_ball.x);
    assign w_x_hi  = SUM_W'(i_ball.x) + SUM_W'(i_ball.size_x);
    assign w_y_lo  = SUM_W'(i_ball.y);
    assign w_y_hi  = SUM_W'(i_ball.y) + SUM_W'(i_ball.size_y);
    assign w_pl_lo = SUM_W'(i_paddle_l_y);
    assign w_pl_hi = SUM_W'(i_paddle_l_y) + SUM_W'(PADDLE_H);
    assign w_pr_lo = SUM_W'(i_paddle_r_y);
    assign w_pr_hi = SUM_W'(i_paddle_r_y) + SUM_W'(PADDLE_H);

    // Half-open interval overlap of [ball_y, ball_y+size_y) with the paddle span.
    assign w_ovl_l = (w_y_lo < w_pl_hi) && (w_y_hi > w_pl_lo);
    assign w_ovl_r = (w_y_lo < w_pr_hi) && (w_y_hi > w_pr_lo);

    assign w_pad_l = (w_x_lo == SUM_W'(PADDLE_L_X + PADDLE_W)) && w_ovl_l;
    assign w_pad_r = (w_x_hi == SUM_W'(PADDLE_R_X)) && w_ovl_r;

    assign o_miss_l = (w_x_lo == '0);
    assign o_miss_r = (w_x_hi == SUM_W'(SCREEN_X));
    assign o_pad    = w_pad_l || w_pad_r;
    assign o_wall   = (w_y_lo == '0) || (w_y_hi == SUM_W'(SCREEN_Y));

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve timing, rally supervision, bounce code hold,
// scoring and game-over handling around the combinational collision checker.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_X    = SCREEN_X_DEF,
    parameter int unsigned SCREEN_Y    = SCREEN_Y_DEF,
    parameter int unsigned PADDLE_L_X  = PADDLE_L_X_DEF,
    parameter int unsigned PADDLE_R_X  = PADDLE_R_X_DEF,
    parameter int unsigned PADDLE_W    = PADDLE_W_DEF,
    parameter int unsigned PADDLE_H    = PADDLE_H_DEF,
    parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
    parameter int unsigned SERVE_DELAY = SERVE_DELAY_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [POS_W-1:0]    ball_x,
    input  logic [POS_W-1:0]    ball_y,
    input  logic [SIZE_W-1:0]   ball_size_x,
    input  logic [SIZE_W-1:0]   ball_size_y,
    input  logic [POS_W-1:0]    paddle_l_y,
    input  logic [POS_W-1:0]    paddle_r_y,
    output logic [BOUNCE_W-1:0] bounce,
    output logic                ball_run,
    output logic [SCORE_W-1:0]  score_l,
    output logic [SCORE_W-1:0]  score_r,
    output logic                game_over,
    output logic [STATE_W-1:0]  state
);

    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY - 1);

    state_t             r_state;
    bounce_t            r_bounce;
    logic [POS_W-1:0]   r_cap_x;
    logic [POS_W-1:0]   r_cap_y;
    logic [CNT_W-1:0]   r_serve_cnt;
    logic [SCORE_W-1:0] r_score_l;
    logic [SCORE_W-1:0] r_score_r;
    logic               r_miss_left;

    ball_t              w_ball;
    logic               w_miss_l;
    logic               w_miss_r;
    logic               w_pad;
    logic               w_wall;
    logic               w_moved;
    logic [SCORE_W-1:0] w_score_l_inc;
    logic [SCORE_W-1:0] w_score_r_inc;

    assign w_ball = '{x: ball_x, y: ball_y, size_x: ball_size_x, size_y: ball_size_y};

    pong_collide #(
        .SCREEN_X   (SCREEN_X),
        .SCREEN_Y   (SCREEN_Y),
        .PADDLE_L_X (PADDLE_L_X),
        .PADDLE_R_X (PADDLE_R_X),
        .PADDLE_W   (PADDLE_W),
        .PADDLE_H   (PADDLE_H)
    ) u_collide (
        .i_ball       (w_ball),
        .i_paddle_l_y (paddle_l_y),
        .i_paddle_r_y (paddle_r_y),
        .o_miss_l     (w_miss_l),
        .o_miss_r     (w_miss_r),
        .o_pad        (w_pad),
        .o_wall       (w_wall)
    );

    assign w_moved       = (ball_x != r_cap_x) || (ball_y != r_cap_y);
    assign w_score_l_inc = score_inc(r_score_l, WIN_VAL);
    assign w_score_r_inc = score_inc(r_score_r, WIN_VAL);

    // Game FSM with serve counter, bounce hold and score registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bounce    <= BOUNCE_NONE;
            r_cap_x     <= '0;
            r_cap_y     <= '0;
            r_serve_cnt <= '0;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_miss_left <= 1'b0;
        end else begin
            r_bounce <= BOUNCE_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_SERVE;
                        r_serve_cnt <= '0;
                    end
                end
                ST_SERVE: begin
                    if (r_serve_cnt == SERVE_LAST) begin
                        r_state     <= ST_PLAY;
                        r_serve_cnt <= '0;
                    end else begin
                        r_serve_cnt <= r_serve_cnt + CNT_W'(1);
                    end
                end
                ST_PLAY: begin
                    r_bounce <= r_bounce;
                    if (w_miss_l || w_miss_r) begin
                        r_state     <= ST_SCORED;
                        r_miss_left <= w_miss_l;
                        r_bounce    <= BOUNCE_NONE;
                    end else if (r_bounce == BOUNCE_NONE) begin
                        // Paddle outranks wall when both touch on the same cycle.
                        if (w_pad) begin
                            r_bounce <= BOUNCE_PADDLE;
                            r_cap_x  <= ball_x;
                            r_cap_y  <= ball_y;
                        end else if (w_wall) begin
                            r_bounce <= BOUNCE_WALL;
                            r_cap_x  <= ball_x;
                            r_cap_y  <= ball_y;
                        end
                    end else if (w_moved) begin
                        r_bounce <= BOUNCE_NONE;
                    end
                end
                ST_SCORED: begin
                    r_serve_cnt <= '0;
                    if (r_miss_left) begin
                        r_score_r <= w_score_r_inc;
                        r_state   <= (w_score_r_inc == WIN_VAL) ? ST_GAME_OVER : ST_SERVE;
                    end else begin
                        r_score_l <= w_score_l_inc;
                        r_state   <= (w_score_l_inc == WIN_VAL) ? ST_GAME_OVER : ST_SERVE;
                    end
                end
                ST_GAME_OVER: begin
                    if (start) begin
                        r_score_l   <= '0;
                        r_score_r   <= '0;
                        r_serve_cnt <= '0;
                        r_state     <= ST_SERVE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bounce    = r_bounce;
    assign ball_run  = (r_state == ST_PLAY);
    assign game_over = (r_state == ST_GAME_OVER);
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign state     = r_state;

endmodule
